// File: rtl/mux2x1_rr_arbiter.sv
// mux2x1_rr_arbiter: round-robin, burst-limited owner of a 2:1 mux with a valid/ready output.
module mux2x1_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req1,
    input  logic [WIDTH-1:0] in1,
    output logic             gnt1,
    input  logic             req2,
    input  logic [WIDTH-1:0] in2,
    output logic             gnt2,
    output logic             s,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic [1:0] {IDLE, SERVE1, SERVE2} state_t;
    state_t        state, state_nxt;
    logic          last2, last2_nxt;
    logic [BW-1:0] bcnt, bcnt_nxt, bcnt_inc;
    logic          xfer, bdone, entering;
    assign out       = s ? in2 : in1;
    assign out_valid = (gnt1 & req1) | (gnt2 & req2);
    always_comb begin
        xfer      = out_valid & out_ready;
        bcnt_inc  = bcnt + 1'b1;
        bdone     = xfer && (bcnt_inc == BW'(MAX_BURST));
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = (req1 && (!req2 || last2)) ? SERVE1 : req2 ? SERVE2 : IDLE;
            SERVE1:  state_nxt = (!req1 || bdone) ? (req2 ? SERVE2 : req1 ? SERVE1 : IDLE) : SERVE1;
            SERVE2:  state_nxt = (!req2 || bdone) ? (req1 ? SERVE1 : req2 ? SERVE2 : IDLE) : SERVE2;
            default: state_nxt = IDLE;
        endcase
        // a burst that ends with nobody waiting restarts the count in place
        entering  = (state_nxt != state) && (state_nxt != IDLE);
        bcnt_nxt  = (entering || bdone || state_nxt == IDLE) ? '0 : xfer ? bcnt_inc : bcnt;
        last2_nxt = entering ? (state_nxt == SERVE2) : last2;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last2 <= 1'b1;
            bcnt  <= '0;
            gnt1  <= 1'b0;
            gnt2  <= 1'b0;
            s     <= 1'b0;
        end else begin
            state <= state_nxt;
            last2 <= last2_nxt;
            bcnt  <= bcnt_nxt;
            gnt1  <= state_nxt == SERVE1;
            gnt2  <= state_nxt == SERVE2;
            s     <= state_nxt == SERVE2;
        end
    end
endmodule
